// File: rtl/vram_scanout.sv
// Pixel-fetch stage: maps VGA hc/vc counters onto a 320x240 8bpp framebuffer shown 2x2,
// hides the VRAM read latency and emits aligned RRRGGGBB colour, syncs and a frame-start pulse.
module vram_scanout #(
    parameter int unsigned HBP         = 144,
    parameter int unsigned HFP         = 784,
    parameter int unsigned VBP         = 31,
    parameter int unsigned VFP         = 511,
    parameter int unsigned FB_WIDTH    = 320,
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic              dclk,
    input  logic              clr,
    input  logic [9:0]        hc,
    input  logic [9:0]        vc,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_en,
    input  logic [7:0]        vram_dout,
    output logic [2:0]        red,
    output logic [2:0]        green,
    output logic [1:0]        blue,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start
);

    localparam logic [9:0]        HBP_C = 10'(HBP);
    localparam logic [9:0]        HFP_C = 10'(HFP);
    localparam logic [9:0]        VBP_C = 10'(VBP);
    localparam logic [9:0]        VFP_C = 10'(VFP);
    localparam logic [ADDR_W-1:0] FB_W_C = ADDR_W'(FB_WIDTH);
    // Stage-0 register plus one stage per cycle of RAM latency.
    localparam int unsigned PD = RAM_LATENCY + 1;

    logic              h_act, v_act, active, line_end, frame_flag;
    logic [9:0]        hc_off;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [ADDR_W-1:0] line_base_d, line_base_q;
    logic              row_sub_d, row_sub_q;
    logic              en_q;
    logic [PD-1:0]     act_q, hs_q, vs_q, fs_q;
    logic [7:0]        rgb_q;
    logic              hsync_q, vsync_q, fs_out_q;

    always_comb begin
        h_act       = (hc >= HBP_C) && (hc < HFP_C);
        v_act       = (vc >= VBP_C) && (vc < VFP_C);
        active      = h_act && v_act;
        hc_off      = hc - HBP_C;
        frame_flag  = (hc == HBP_C) && (vc == VBP_C);
        line_end    = (hc == HFP_C - 10'd1) && v_act;
        addr_d      = active ? line_base_q + ADDR_W'(hc_off >> 1) : addr_q;
        line_base_d = line_base_q;
        row_sub_d   = row_sub_q;
        // Each framebuffer row is shown on two display lines; advance after the second.
        if (vc < VBP_C) begin
            line_base_d = '0;
            row_sub_d   = 1'b0;
        end else if (line_end) begin
            row_sub_d = ~row_sub_q;
            if (row_sub_q) begin
                line_base_d = line_base_q + FB_W_C;
            end
        end
    end

    always_ff @(posedge dclk or negedge clr) begin
        if (!clr) begin
            addr_q      <= '0;
            en_q        <= 1'b0;
            line_base_q <= '0;
            row_sub_q   <= 1'b0;
            act_q       <= '0;
            hs_q        <= '1;
            vs_q        <= '1;
            fs_q        <= '0;
            rgb_q       <= 8'h00;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            fs_out_q    <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            en_q        <= active;
            line_base_q <= line_base_d;
            row_sub_q   <= row_sub_d;
            act_q       <= {act_q[PD-2:0], active};
            hs_q        <= {hs_q[PD-2:0], hsync_in};
            vs_q        <= {vs_q[PD-2:0], vsync_in};
            fs_q        <= {fs_q[PD-2:0], frame_flag};
            rgb_q       <= act_q[PD-1] ? vram_dout : 8'h00;
            hsync_q     <= hs_q[PD-1];
            vsync_q     <= vs_q[PD-1];
            fs_out_q    <= fs_q[PD-1];
        end
    end

    assign vram_addr   = addr_q;
    assign vram_en     = en_q;
    assign red         = rgb_q[7:5];
    assign green       = rgb_q[4:2];
    assign blue        = rgb_q[1:0];
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_out_q;

endmodule

// File: tb/tb_vram_scanout.sv
// Bench for vram_scanout on a shrunken raster, with RAM latencies 1 and 2 side by side,
// checked against a per-pixel model of address, colour, sync delay and frame-start.
module tb_vram_scanout;

    localparam int HBP = 5, HFP = 13, HTOT = 16;
    localparam int VBP = 3, VFP = 9, VTOT = 11;
    localparam int FBW = 4;
    localparam int FRAME = HTOT * VTOT;
    localparam int EN_PER_FRAME = (HFP - HBP) * (VFP - VBP);

    typedef struct packed {
        logic        act;
        logic [16:0] addr;
        logic        hs;
        logic        vs;
        logic        fs;
    } ent_t;

    logic        dclk = 1'b0;
    logic        clr;
    logic [9:0]  hc, vc;
    logic        hs_in, vs_in;
    logic [16:0] addr1, addr2;
    logic        en1, en2;
    logic [7:0]  dout1, dout2, d2a;
    logic [2:0]  r1, g1, r2, g2;
    logic [1:0]  b1, b2;
    logic        hs1, vs1, fs1, hs2, vs2, fs2;
    logic [7:0]  mem [0:255];

    int   errors = 0;
    int   checks = 0;
    int   gen_hc = 0;
    int   gen_vc = 0;
    ent_t hist[$];

    vram_scanout #(.HBP(HBP), .HFP(HFP), .VBP(VBP), .VFP(VFP), .FB_WIDTH(FBW),
                   .ADDR_W(17), .RAM_LATENCY(1)) u_dut1 (
        .dclk(dclk), .clr(clr), .hc(hc), .vc(vc), .hsync_in(hs_in), .vsync_in(vs_in),
        .vram_addr(addr1), .vram_en(en1), .vram_dout(dout1), .red(r1), .green(g1),
        .blue(b1), .hsync(hs1), .vsync(vs1), .frame_start(fs1)
    );

    vram_scanout #(.HBP(HBP), .HFP(HFP), .VBP(VBP), .VFP(VFP), .FB_WIDTH(FBW),
                   .ADDR_W(17), .RAM_LATENCY(2)) u_dut2 (
        .dclk(dclk), .clr(clr), .hc(hc), .vc(vc), .hsync_in(hs_in), .vsync_in(vs_in),
        .vram_addr(addr2), .vram_en(en2), .vram_dout(dout2), .red(r2), .green(g2),
        .blue(b2), .hsync(hs2), .vsync(vs2), .frame_start(fs2)
    );

    always #5 dclk = ~dclk;

    always_ff @(posedge dclk) begin
        dout1 <= mem[addr1[7:0]];
        d2a   <= mem[addr2[7:0]];
        dout2 <= d2a;
    end

    function automatic ent_t make_ent(int h, int v, logic s_h, logic s_v);
        ent_t e;
        e.act  = (h >= HBP) && (h < HFP) && (v >= VBP) && (v < VFP);
        e.addr = e.act ? 17'(((v - VBP) / 2) * FBW + (h - HBP) / 2) : 17'h0;
        e.hs   = s_h;
        e.vs   = s_v;
        e.fs   = (h == HBP) && (v == VBP);
        return e;
    endfunction

    function automatic ent_t reset_ent();
        ent_t e;
        e.act  = 1'b0;
        e.addr = 17'h0;
        e.hs   = 1'b1;
        e.vs   = 1'b1;
        e.fs   = 1'b0;
        return e;
    endfunction

    function automatic logic [7:0] exp_rgb(ent_t c);
        return c.act ? mem[c.addr[7:0]] : 8'h00;
    endfunction

    task automatic init_hist();
        hist.delete();
        repeat (8) hist.push_back(reset_ent());
    endtask

    task automatic present();
        hc    = 10'(gen_hc);
        vc    = 10'(gen_vc);
        hs_in = 1'($urandom_range(0, 1));
        vs_in = 1'($urandom_range(0, 1));
    endtask

    task automatic fill_mem_random();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    endtask

    // One pixel clock: record what the DUT samples at this edge, then advance the raster.
    task automatic tick();
        ent_t e;
        e = clr ? make_ent(gen_hc, gen_vc, hs_in, vs_in) : reset_ent();
        @(posedge dclk);
        #1;
        hist.push_back(e);
        if (hist.size() > 8) void'(hist.pop_front());
        gen_hc++;
        if (gen_hc == HTOT) begin
            gen_hc = 0;
            gen_vc = (gen_vc + 1) % VTOT;
        end
        present();
    endtask

    task automatic test_reset();
        logic [33:0] rst_val;
        rst_val = {8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 17'h0};
        clr = 1'b1;
        gen_hc = 0;
        gen_vc = 0;
        present();
        fill_mem_random();
        #2 clr = 1'b0;
        init_hist();
        gen_hc = $urandom_range(0, HTOT - 1);
        gen_vc = $urandom_range(0, VTOT - 1);
        present();
        repeat (5) begin
            tick();
            checks++;
            if ({r1, g1, b1, hs1, vs1, fs1, en1, addr1} !== rst_val) begin
                errors++;
                $display("FAIL reset_l1: got %h want %h", {r1, g1, b1, hs1, vs1, fs1, en1, addr1},
                         rst_val);
            end
            checks++;
            if ({r2, g2, b2, hs2, vs2, fs2, en2, addr2} !== rst_val) begin
                errors++;
                $display("FAIL reset_l2: got %h want %h", {r2, g2, b2, hs2, vs2, fs2, en2, addr2},
                         rst_val);
            end
        end
        gen_hc = 0;
        gen_vc = 0;
        present();
        clr = 1'b1;
    endtask

    task automatic test_frame();
        ent_t a, c1, c2;
        int   en_cnt1 = 0, en_cnt2 = 0, fs_cnt1 = 0, fs_cnt2 = 0;
        int   fs_at1[$], fs_at2[$];
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            a  = hist[$];
            c1 = hist[$-2];
            c2 = hist[$-3];
            if (en1) en_cnt1++;
            if (en2) en_cnt2++;
            if (fs1) begin fs_cnt1++; fs_at1.push_back(i); end
            if (fs2) begin fs_cnt2++; fs_at2.push_back(i); end
            checks++;
            if ({en1, en2} !== {a.act, a.act}) begin
                errors++;
                $display("FAIL frame_en @%0d: got %b%b want %b", i, en1, en2, a.act);
            end
            if (a.act) begin
                checks++;
                if (addr1 !== a.addr || addr2 !== a.addr) begin
                    errors++;
                    $display("FAIL frame_addr @%0d: got %0d/%0d want %0d", i, addr1, addr2, a.addr);
                end
            end
            checks++;
            if ({r1, g1, b1, hs1, vs1, fs1} !== {exp_rgb(c1), c1.hs, c1.vs, c1.fs}) begin
                errors++;
                $display("FAIL frame_out_l1 @%0d: got %h want %h", i, {r1, g1, b1, hs1, vs1, fs1},
                         {exp_rgb(c1), c1.hs, c1.vs, c1.fs});
            end
            checks++;
            if ({r2, g2, b2, hs2, vs2, fs2} !== {exp_rgb(c2), c2.hs, c2.vs, c2.fs}) begin
                errors++;
                $display("FAIL frame_out_l2 @%0d: got %h want %h", i, {r2, g2, b2, hs2, vs2, fs2},
                         {exp_rgb(c2), c2.hs, c2.vs, c2.fs});
            end
        end
        checks++;
        if (en_cnt1 != 2 * EN_PER_FRAME || en_cnt2 != 2 * EN_PER_FRAME) begin
            errors++;
            $display("FAIL en_count: got %0d/%0d want %0d", en_cnt1, en_cnt2, 2 * EN_PER_FRAME);
        end
        checks++;
        if (fs_cnt1 != 2 || fs_cnt2 != 2) begin
            errors++;
            $display("FAIL fs_count: got %0d/%0d want 2", fs_cnt1, fs_cnt2);
        end else begin
            checks++;
            if (fs_at1[0] != VBP * HTOT + HBP + 2 || fs_at2[0] != VBP * HTOT + HBP + 3) begin
                errors++;
                $display("FAIL fs_latency: got %0d/%0d want %0d/%0d", fs_at1[0], fs_at2[0],
                         VBP * HTOT + HBP + 2, VBP * HTOT + HBP + 3);
            end
            checks++;
            if (fs_at1[1] - fs_at1[0] != FRAME || fs_at2[1] - fs_at2[0] != FRAME) begin
                errors++;
                $display("FAIL fs_spacing: got %0d/%0d want %0d", fs_at1[1] - fs_at1[0],
                         fs_at2[1] - fs_at2[0], FRAME);
            end
        end
    endtask

    task automatic test_blanking();
        ent_t       c1, c2;
        logic [7:0] w1, w2;
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            c1 = hist[$-2];
            c2 = hist[$-3];
            w1 = c1.act ? 8'hFF : 8'h00;
            w2 = c2.act ? 8'hFF : 8'h00;
            checks++;
            if ({r1, g1, b1} !== w1 || {r2, g2, b2} !== w2) begin
                errors++;
                $display("FAIL blank @%0d: got %h/%h want %h/%h", i, {r1, g1, b1}, {r2, g2, b2},
                         w1, w2);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [33:0] rst_val;
        ent_t        a;
        int          guard = 0, en_cnt1 = 0, en_cnt2 = 0;
        rst_val = {8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 17'h0};
        fill_mem_random();
        while (!(gen_hc == 8 && gen_vc == 6) && guard < 2 * FRAME) begin
            tick();
            guard++;
        end
        tick();
        clr = 1'b0;
        #1;
        checks++;
        if ({r1, g1, b1, hs1, vs1, fs1, en1, addr1} !== rst_val ||
            {r2, g2, b2, hs2, vs2, fs2, en2, addr2} !== rst_val) begin
            errors++;
            $display("FAIL midreset_immediate: got %h/%h want %h",
                     {r1, g1, b1, hs1, vs1, fs1, en1, addr1},
                     {r2, g2, b2, hs2, vs2, fs2, en2, addr2}, rst_val);
        end
        init_hist();
        repeat (3) tick();
        clr = 1'b1;
        guard = 0;
        while (!(gen_hc == 0 && gen_vc == 0) && guard < 2 * FRAME) begin
            tick();
            guard++;
        end
        for (int i = 0; i < FRAME; i++) begin
            tick();
            a = hist[$];
            if (en1) en_cnt1++;
            if (en2) en_cnt2++;
            checks++;
            if ({en1, en2} !== {a.act, a.act}) begin
                errors++;
                $display("FAIL midreset_en @%0d: got %b%b want %b", i, en1, en2, a.act);
            end
            if (a.act) begin
                checks++;
                if (addr1 !== a.addr || addr2 !== a.addr) begin
                    errors++;
                    $display("FAIL midreset_addr @%0d: got %0d/%0d want %0d", i, addr1, addr2,
                             a.addr);
                end
            end
        end
        checks++;
        if (en_cnt1 != EN_PER_FRAME || en_cnt2 != EN_PER_FRAME) begin
            errors++;
            $display("FAIL midreset_en_count: got %0d/%0d want %0d", en_cnt1, en_cnt2,
                     EN_PER_FRAME);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_blanking();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
